// File: rtl/vector_rf_dualport.sv
// Vector register file with one synchronous read port and one write port.
//
// Each register holds NUM_ELEMS elements of ELEM_SIZE bits. Every element is
// split into ENABLES_PER_ELEMENT slices, and each slice has its own write
// enable. A read and a write in the same cycle to the same address behave
// write-first: the read returns the freshly merged value.
// After reset, or on a clear request, a zeroing sequence writes all-zero to
// every entry (one entry per clock) before requests are accepted again.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   clear        request re-zeroing of all registers (honoured in RUN only)
//   ready        high while read/write requests are accepted
//   re, raddr    read enable / address; data_r is loaded one edge later
//   data_r       read data (element 0 at the LSBs)
//   data_r_valid data_r was updated by an accepted read at the previous edge
//   we, waddr    write enable / address
//   write_mask   bit i*ENABLES_PER_ELEMENT+j enables element i, slice j
//   data_w       write data
module vector_rf_dualport #(
  parameter  int NUM_ELEMS           = 8,
  parameter  int ELEM_SIZE           = 16,
  parameter  int ENABLES_PER_ELEMENT = 4,
  parameter  int VRF_SIZE            = 32,
  localparam int W  = NUM_ELEMS * ELEM_SIZE,
  localparam int SW = ELEM_SIZE / ENABLES_PER_ELEMENT,
  localparam int AW = (VRF_SIZE > 1) ? $clog2(VRF_SIZE) : 1,
  localparam int MW = NUM_ELEMS * ENABLES_PER_ELEMENT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic          ready,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  data_r,
  output logic          data_r_valid,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [MW-1:0] write_mask,
  input  logic [W-1:0]  data_w
);

  if (ELEM_SIZE % ENABLES_PER_ELEMENT != 0) begin : g_bad_slicing
    $error("vector_rf_dualport: ELEM_SIZE must be a multiple of ENABLES_PER_ELEMENT");
  end

  localparam logic [AW-1:0] LAST  = AW'(VRF_SIZE - 1);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(VRF_SIZE);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  // Mask bit k covers data bits [k*SW +: SW], which is exactly element
  // k/ENABLES_PER_ELEMENT, slice k%ENABLES_PER_ELEMENT.
  function automatic logic [W-1:0] merge_slices(input logic [W-1:0]  old_v,
                                                input logic [W-1:0]  new_v,
                                                input logic [MW-1:0] m);
    logic [W-1:0] res;
    res = old_v;
    for (int k = 0; k < MW; k++) begin
      if (m[k]) res[k*SW +: SW] = new_v[k*SW +: SW];
    end
    return res;
  endfunction

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  mem [VRF_SIZE];

  logic         run_ok;
  logic         raddr_ok, waddr_ok;
  logic         rd_fire, wr_fire;
  logic [W-1:0] rd_old, rd_val;

  // ---- control: zeroing sequencer ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (clear) begin
          state_nxt = S_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign ready = (state == S_RUN);

  // A clear cycle swallows any read or write issued alongside it.
  assign run_ok   = (state == S_RUN) && !clear;
  assign raddr_ok = ({1'b0, raddr} < DEPTH);
  assign waddr_ok = ({1'b0, waddr} < DEPTH);
  assign rd_fire  = run_ok && re;
  assign wr_fire  = run_ok && we && waddr_ok;

  // Out-of-range reads return zero rather than aliasing a real entry.
  assign rd_old = raddr_ok ? mem[raddr] : '0;
  assign rd_val = (wr_fire && raddr_ok && (raddr == waddr))
                ? merge_slices(rd_old, data_w, write_mask) : rd_old;

  // ---- storage update ----
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= '0;
    end else if (wr_fire) begin
      mem[waddr] <= merge_slices(mem[waddr], data_w, write_mask);
    end
  end

  // ---- read output register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r       <= '0;
      data_r_valid <= 1'b0;
    end else begin
      data_r_valid <= rd_fire;
      if (rd_fire) data_r <= rd_val;
    end
  end

endmodule

// File: tb/tb_vector_rf_dualport.sv
module tb_vector_rf_dualport;

  logic         clk = 1'b0;
  // default instance (VRF_SIZE=32)
  logic         reset, clear, re, we;
  logic [4:0]   raddr, waddr;
  logic [31:0]  mask;
  logic [127:0] data_w;
  logic         ready, data_r_valid;
  logic [127:0] data_r;
  // reduced-depth instance (VRF_SIZE=20)
  logic         reset_b, clear_b, re_b, we_b;
  logic [4:0]   raddr_b, waddr_b;
  logic [31:0]  mask_b;
  logic [127:0] data_w_b;
  logic         ready_b, data_r_valid_b;
  logic [127:0] data_r_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vector_rf_dualport dut (
    .clk(clk), .reset(reset), .clear(clear), .ready(ready),
    .re(re), .raddr(raddr), .data_r(data_r), .data_r_valid(data_r_valid),
    .we(we), .waddr(waddr), .write_mask(mask), .data_w(data_w)
  );

  vector_rf_dualport #(.VRF_SIZE(20)) dut_b (
    .clk(clk), .reset(reset_b), .clear(clear_b), .ready(ready_b),
    .re(re_b), .raddr(raddr_b), .data_r(data_r_b), .data_r_valid(data_r_valid_b),
    .we(we_b), .waddr(waddr_b), .write_mask(mask_b), .data_w(data_w_b)
  );

  typedef struct {
    logic         we;
    logic [4:0]   waddr;
    logic [31:0]  mask;
    logic [127:0] wd;
    logic         re;
    logic [4:0]   raddr;
    logic         ev;
    logic [127:0] ed;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready rises; also checks data_r_valid stays low meanwhile.
  task automatic count_ready(input bit sel_b, input int exp_edges, input string name);
    int  n = 0;
    bit  saw_valid = 1'b0;
    while (n < 200) begin
      step();
      n++;
      if (sel_b ? ready_b : ready) break;
      if (sel_b ? data_r_valid_b : data_r_valid) saw_valid = 1'b1;
    end
    chk({name, "_edges"}, 128'(n), 128'(exp_edges));
    chk({name, "_valid_low"}, 128'(saw_valid), 128'(0));
  endtask

  task automatic idle_a;
    clear = 0; re = 0; we = 0; raddr = 0; waddr = 0; mask = 0; data_w = 0;
  endtask

  task automatic read_b(input logic [4:0] a, input logic [127:0] exp, input string name);
    re_b = 1; raddr_b = a; we_b = 0;
    step();
    chk({name, "_data"}, data_r_b, exp);
    chk({name, "_valid"}, 128'(data_r_valid_b), 128'(1));
    re_b = 0;
  endtask

  initial begin
    idle_a();
    reset = 1;
    reset_b = 1; clear_b = 0; re_b = 0; we_b = 0; raddr_b = 0; waddr_b = 0;
    mask_b = 0; data_w_b = 0;

    tbl[0]  = '{1, 3,  32'h0000_0001, {128{1'b1}},     0, 0,  0, 128'h0};
    tbl[1]  = '{0, 0,  32'h0,         128'h0,          1, 3,  1, 128'hF};
    tbl[2]  = '{1, 3,  32'hFFFF_FFFF, {8{16'h1234}},   0, 0,  0, 128'hF};
    tbl[3]  = '{0, 0,  32'h0,         128'h0,          1, 3,  1, {8{16'h1234}}};
    tbl[4]  = '{1, 3,  32'h0,         128'h0,          1, 3,  1, {8{16'h1234}}};
    tbl[5]  = '{1, 7,  32'hFFFF_FFFF, {8{16'hAAAA}},   0, 0,  0, {8{16'h1234}}};
    tbl[6]  = '{1, 7,  32'h0000_000F, {8{16'h5555}},   1, 7,  1, {{7{16'hAAAA}}, 16'h5555}};
    tbl[7]  = '{0, 0,  32'h0,         128'h0,          1, 7,  1, {{7{16'hAAAA}}, 16'h5555}};
    tbl[8]  = '{1, 11, 32'hFFFF_FFFF, {8{16'hC0DE}},   0, 0,  0, {{7{16'hAAAA}}, 16'h5555}};
    tbl[9]  = '{1, 10, 32'hFFFF_FFFF, {8{16'hBEEF}},   1, 11, 1, {8{16'hC0DE}}};
    tbl[10] = '{0, 0,  32'h0,         128'h0,          1, 10, 1, {8{16'hBEEF}}};
    tbl[11] = '{1, 10, 32'hF000_0000, {8{16'h1111}},   1, 10, 1, {16'h1111, {7{16'hBEEF}}}};
    tbl[12] = '{1, 3,  32'h0000_0030, {8{16'h9876}},   1, 3,  1, {{6{16'h1234}}, 16'h1276, 16'h1234}};

    // Reset values
    step(); step();
    chk("rst_data_r", data_r, 128'h0);
    chk("rst_valid", 128'(data_r_valid), 128'(0));
    chk("rst_ready", 128'(ready), 128'(0));

    // INIT length with a read held pending, then first accepted read
    re = 1; raddr = 5;
    reset = 0;
    count_ready(0, 32, "init_a");
    step();
    chk("first_read_data", data_r, 128'h0);
    chk("first_read_valid", 128'(data_r_valid), 128'(1));

    // Table-driven masked writes, bypass and mixed-address cases
    for (int i = 0; i < 13; i++) begin
      we = tbl[i].we; waddr = tbl[i].waddr; mask = tbl[i].mask; data_w = tbl[i].wd;
      re = tbl[i].re; raddr = tbl[i].raddr;
      step();
      chk($sformatf("vec%0d_data", i), data_r, tbl[i].ed);
      chk($sformatf("vec%0d_valid", i), 128'(data_r_valid), 128'(tbl[i].ev));
    end
    idle_a();

    // clear with a pending write and read: both dropped
    clear = 1; we = 1; waddr = 4; mask = 32'hFFFF_FFFF; data_w = {8{16'hFFFF}};
    re = 1; raddr = 3;
    step();
    chk("clear_read_dropped", 128'(data_r_valid), 128'(0));
    chk("clear_ready_low", 128'(ready), 128'(0));
    idle_a();
    count_ready(0, 32, "clear_init");
    begin
      logic [4:0] addrs [5];
      addrs = '{5'd3, 5'd7, 5'd4, 5'd10, 5'd11};
      for (int i = 0; i < 5; i++) begin
        re = 1; raddr = addrs[i];
        step();
        chk($sformatf("post_clear_rd%0d", addrs[i]), data_r, 128'h0);
        chk($sformatf("post_clear_v%0d", addrs[i]), 128'(data_r_valid), 128'(1));
      end
    end
    idle_a();

    // Reset mid-RUN: outputs drop asynchronously
    we = 1; waddr = 3; mask = 32'hFFFF_FFFF; data_w = {8{16'hABCD}};
    step();
    we = 0; re = 1; raddr = 3;
    step();
    chk("pre_reset_data", data_r, {8{16'hABCD}});
    re = 0;
    reset = 1;
    #1;
    chk("async_rst_data", data_r, 128'h0);
    chk("async_rst_valid", 128'(data_r_valid), 128'(0));
    chk("async_rst_ready", 128'(ready), 128'(0));
    step();
    reset = 0;
    count_ready(0, 32, "run_rst_init");

    // Reset mid-INIT at cnt=12: full INIT length again
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 12; i++) step();
    chk("midinit_ready_low", 128'(ready), 128'(0));
    reset = 1;
    #1;
    reset = 0;
    count_ready(0, 32, "midinit_rst_init");

    // Reduced-depth instance: out-of-range address handling
    reset_b = 0;
    count_ready(1, 20, "init_b");
    we_b = 1; waddr_b = 9; mask_b = 32'hFFFF_FFFF; data_w_b = {8{16'h1357}};
    step();
    we_b = 1; waddr_b = 25; data_w_b = {8{16'hDEAD}};
    re_b = 1; raddr_b = 25;
    step();
    chk("b_oor_bypass_data", data_r_b, 128'h0);
    chk("b_oor_bypass_valid", 128'(data_r_valid_b), 128'(1));
    we_b = 0;
    read_b(9, {8{16'h1357}}, "b_rd9");
    for (int a = 0; a < 20; a++) begin
      if (a != 9) read_b(5'(a), 128'h0, $sformatf("b_noalias%0d", a));
    end
    read_b(25, 128'h0, "b_rd25");
    read_b(31, 128'h0, "b_rd31");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_rf_dualport.md
Name: vector_rf_dualport

Overview:
- Parametrised vector register file: one synchronous read port and one write port, usable in the same cycle.
- Each element is split into nibble/byte slices, each with its own write enable.
- Write-first bypass: a read sees a write to the same address in the same cycle.
- Hardware zero-initialisation FSM runs after reset and on demand.
- Sits in the vector unit between instruction decode and the vector ALUs.
- Generalises the single-port, fixed-128-bit macro wrapper to arbitrary width and depth, with no macro dependency.

Parameters:
- NUM_ELEMS, 8, number of vector elements per register.
- ELEM_SIZE, 16, bits per element.
- ENABLES_PER_ELEMENT, 4, write-enable slices per element; must divide ELEM_SIZE.
- VRF_SIZE, 32, number of vector registers; need not be a power of two.
- Derived: W = NUM_ELEMS*ELEM_SIZE; SW = ELEM_SIZE/ENABLES_PER_ELEMENT; AW = max(1,$clog2(VRF_SIZE)); MW = NUM_ELEMS*ENABLES_PER_ELEMENT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  request re-zeroing of all registers.
- ready  out  1  high when read and write requests are accepted.
- re  in  1  read enable.
- raddr  in  AW  read address.
- data_r  out  W  read data.
- data_r_valid  out  1  data_r updated by an accepted read at the previous edge.
- we  in  1  write enable.
- waddr  in  AW  write address.
- write_mask  in  MW  bit i*ENABLES_PER_ELEMENT+j enables element i, slice j.
- data_w  in  W  write data.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Bit mapping: element i = data[i*ELEM_SIZE +: ELEM_SIZE]; its slice j = data[i*ELEM_SIZE + j*SW +: SW]; element 0 is at the LSBs.
- Reset values: data_r=0, data_r_valid=0, ready=0, state=INIT, init counter=0. Storage contents are undefined until INIT completes.
- INIT state:
  - Each rising edge writes all-zero to entry cnt, then cnt increments.
  - The edge that clears entry VRF_SIZE-1 moves to RUN and sets ready=1.
  - ready therefore rises exactly VRF_SIZE edges after reset deasserts.
  - re, we and clear are ignored (clear does not restart the counter).
  - data_r holds its value; data_r_valid=0.
- RUN state:
  - clear=1 at an edge: move to INIT with cnt=0, ready=0. Any re/we in that same cycle is ignored.
  - Write: we=1 at an edge updates only the slices of mem[waddr] whose mask bit is 1; other slices are retained. An all-zero mask is a no-op.
  - Read: re=1 at an edge loads data_r one cycle later (latency 1) and sets data_r_valid=1. Otherwise data_r holds and data_r_valid=0.
  - Bypass: if re & we & raddr==waddr, data_r = old contents with masked slices replaced by data_w (write-first).
  - Out-of-range address (>= VRF_SIZE): the write is dropped; the read returns all-zero with data_r_valid=1.
- Reset mid-operation: asserting reset at any time returns all state to reset values immediately and restarts INIT.
- Elaboration check, simulation only: error if ELEM_SIZE % ENABLES_PER_ELEMENT != 0.
- Storage is inferred (flops or compiler RAM); no vendor macro instantiation.

Test Plan (default parameters; W=128, MW=32, SW=4):
- Reset release, then re=1 raddr=5 asserted throughout → ready=0 for 32 edges, ready=1 after the 32nd. First accepted read gives data_r=0 and data_r_valid=1 one cycle later.
- Masked write: we=1, waddr=3, data_w=all-F, mask=0x0000_0001; then read 3 → data_r=0x...000F (only element 0, slice 0 written). Follow with mask=0xFFFF_FFFF, data_w=0x1234 replicated → full value reads back.
- Write-first bypass: mem[7] preloaded with 0xAAAA per element. Same cycle: we=1, re=1, waddr=raddr=7, mask=0x0000_000F, data_w=0x5555 per element → data_r element 0 = 0x5555, elements 1..7 = 0xAAAA. Next read of 7 gives the same value.
- Simultaneous different addresses: write 10 and read 11 in the same cycle → data_r = old mem[11]; a later read of 10 returns the new data.
- clear in RUN with pending we to 4 → write dropped, ready low for 32 edges. All entries read 0 afterwards, including previously written 3 and 7.
- VRF_SIZE=20 variant: write to address 25 is dropped and does not alias entry 9 or any other entry. Read of 25 returns 0 with data_r_valid=1. INIT lasts 20 edges.
- Reset asserted mid-INIT at cnt=12 and mid-RUN → outputs return to 0 immediately (asynchronously). Full INIT length is observed again after release.
